// File: rtl/pll_rst_pkg.sv
// pll_rst_pkg: shared state encoding and loss-counter constants for the PLL reset sequencer
package pll_rst_pkg;
    typedef enum logic [2:0] {HOLD, WAIT_LOCK, STABLE, RELEASE, RUN} state_t;
    localparam int LOSS_CNT_W = 8;
    localparam logic [LOSS_CNT_W-1:0] LOSS_CNT_MAX = 8'hFF;
endpackage

// File: rtl/pll_reset_sequencer_sync2.sv
// sync2: two-flop synchroniser with asynchronous active-high reset to 0
module sync2 (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);
    logic m;
    always_ff @(posedge clk or posedge rst)
        if (rst) {q, m} <= 2'b00;
        else     {q, m} <= {m, d};
endmodule

// File: rtl/pll_reset_sequencer.sv
// pll_reset_sequencer: qualifies PLL lock, releases staged resets in order, then runs a periodic tick
module pll_reset_sequencer
    import pll_rst_pkg::*;
#(
    parameter int LOCK_CYCLES  = 1024,
    parameter int STAGES       = 2,
    parameter int STAGE_CYCLES = 16,
    parameter int TICK_DIV     = 27
) (
    input  logic                  CLKIN,
    input  logic                  RESET,
    input  logic                  lock,
    input  logic                  sw_rst,
    output logic [STAGES-1:0]     rst_stage,
    output logic                  ready,
    output logic                  tick,
    output logic [LOSS_CNT_W-1:0] lock_loss_cnt
);
    localparam int REL = STAGES * STAGE_CYCLES;
    localparam int LW  = LOCK_CYCLES > 1 ? $clog2(LOCK_CYCLES) : 1;
    localparam int SW  = REL > 1 ? $clog2(REL) : 1;
    localparam int TW  = TICK_DIV > 1 ? $clog2(TICK_DIV) : 1;
    localparam logic [LW-1:0] LLAST = LW'(LOCK_CYCLES - 1);
    localparam logic [SW-1:0] SLAST = SW'(REL - 1);
    localparam logic [TW-1:0] TLAST = TW'(TICK_DIV - 1);
    localparam logic [STAGES-1:0] FIRST = ~STAGES'(1);

    state_t state, nxt;
    logic lock_s, active, abort, loss;
    logic [LW-1:0] lcnt, lcnt_n;
    logic [SW-1:0] scnt, scnt_n;
    logic [TW-1:0] tcnt, tcnt_n;
    logic [STAGES-1:0] clr, rs_n;
    logic ready_n, tick_n;
    logic [LOSS_CNT_W-1:0] loss_n;

    sync2 u_lock_sync (.clk(CLKIN), .rst(RESET), .d(lock), .q(lock_s));

    // clr[i] marks the edge, counted from the bit-0 release, at which stage i lets go
    assign clr[0] = 1'b0;
    for (genvar i = 1; i < STAGES; i++) begin : g_clr
        localparam logic [SW-1:0] TH = SW'(i * STAGE_CYCLES - 1);
        assign clr[i] = scnt == TH;
    end

    assign active = state == RELEASE || state == RUN;
    assign abort  = active && (!lock_s || sw_rst);
    assign loss   = active && !lock_s;

    always_ff @(posedge CLKIN or posedge RESET)
        if (RESET) begin
            state         <= HOLD;
            lcnt          <= '0;
            scnt          <= '0;
            tcnt          <= '0;
            rst_stage     <= '1;
            ready         <= 1'b0;
            tick          <= 1'b0;
            lock_loss_cnt <= '0;
        end else begin
            state         <= nxt;
            lcnt          <= lcnt_n;
            scnt          <= scnt_n;
            tcnt          <= tcnt_n;
            rst_stage     <= rs_n;
            ready         <= ready_n;
            tick          <= tick_n;
            lock_loss_cnt <= loss_n;
        end

    always_comb begin
        nxt = state;
        case (state)
            HOLD:      nxt = WAIT_LOCK;
            WAIT_LOCK: nxt = lock_s && !sw_rst ? STABLE : WAIT_LOCK;
            STABLE:    nxt = !lock_s || sw_rst ? WAIT_LOCK : lcnt == LLAST ? RELEASE : STABLE;
            RELEASE:   nxt = abort ? WAIT_LOCK : scnt == SLAST ? RUN : RELEASE;
            RUN:       nxt = abort ? WAIT_LOCK : RUN;
            default:   nxt = HOLD;
        endcase
    end

    always_comb begin
        lcnt_n  = state == STABLE && nxt == STABLE ? lcnt + 1'b1 : '0;
        scnt_n  = state == RELEASE && nxt == RELEASE ? scnt + 1'b1 : '0;
        tcnt_n  = state == RUN && nxt == RUN && tcnt != TLAST ? tcnt + 1'b1 : '0;
        tick_n  = state == RUN && nxt == RUN && tcnt == TLAST;
        ready_n = nxt == RUN;
        rs_n    = nxt == RUN ? '0 : nxt != RELEASE ? '1 : state == STABLE ? FIRST : rst_stage & ~clr;
        loss_n  = loss && lock_loss_cnt != LOSS_CNT_MAX ? lock_loss_cnt + 1'b1 : lock_loss_cnt;
    end
endmodule

// File: tb/tb_pll_reset_sequencer.sv
// tb_pll_reset_sequencer: directed bring-up tables, corner sequences and randomized lock/sw_rst/RESET vs a timeline model
module tb_pll_reset_sequencer;
    localparam int LC = 4, SC = 2, ST = 2, TD = 3, R = ST * SC;

    typedef struct {
        int         e;
        logic [1:0] rs;
        logic       rdy;
        logic       tk;
    } vec_t;

    logic CLKIN = 1'b0, RESET = 1'b1, lock = 1'b0, sw_rst = 1'b0;
    logic [ST-1:0] rs, rs1;
    logic rdy, rdy1, tk, tk1;
    logic [7:0] loss, loss1;
    int checks = 0, errors = 0;
    vec_t bring [13];

    pll_reset_sequencer #(.LOCK_CYCLES(LC), .STAGES(ST), .STAGE_CYCLES(SC), .TICK_DIV(TD)) u_dut (
        .CLKIN(CLKIN), .RESET(RESET), .lock(lock), .sw_rst(sw_rst),
        .rst_stage(rs), .ready(rdy), .tick(tk), .lock_loss_cnt(loss));

    pll_reset_sequencer #(.LOCK_CYCLES(LC), .STAGES(ST), .STAGE_CYCLES(SC), .TICK_DIV(1)) u_dut1 (
        .CLKIN(CLKIN), .RESET(RESET), .lock(lock), .sw_rst(sw_rst),
        .rst_stage(rs1), .ready(rdy1), .tick(tk1), .lock_loss_cnt(loss1));

    always #5 CLKIN = ~CLKIN;

    // Timeline model: mode 0 held, 1 waiting, 2 qualifying (q cycles), 3 released t edges ago
    int mode = 0, q = 0, t = 0, mloss = 0;
    logic h1 = 1'b0, h2 = 1'b0;
    always @(posedge CLKIN or posedge RESET) begin
        if (RESET) begin
            mode <= 0; q <= 0; t <= 0; mloss <= 0; h1 <= 1'b0; h2 <= 1'b0;
        end else begin
            h1 <= lock;
            h2 <= h1;
            if (mode == 0) mode <= 1;
            else if (mode == 1) begin
                if (h2 && !sw_rst) begin mode <= 2; q <= 0; end
            end else if (mode == 2) begin
                if (!h2 || sw_rst) mode <= 1;
                else if (q == LC - 1) begin mode <= 3; t <= 0; end
                else q <= q + 1;
            end else begin
                if (!h2) begin mode <= 1; mloss <= mloss == 255 ? 255 : mloss + 1; end
                else if (sw_rst) mode <= 1;
                else t <= t + 1;
            end
        end
    end

    function automatic logic [ST-1:0] m_rs();
        logic [ST-1:0] r;
        for (int i = 0; i < ST; i++) r[i] = !(mode == 3 && t >= i * SC);
        return r;
    endfunction

    function automatic logic m_ready();
        return mode == 3 && t >= R;
    endfunction

    function automatic logic m_tick(input int td);
        return mode == 3 && t > R && (t - R) % td == 0;
    endfunction

    task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
        checks++;
        if (a !== e) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", n, a, e, $time);
        end
    endtask

    task automatic cmp_model();
        chk("model_rst_stage", 32'(rs), 32'(m_rs()));
        chk("model_ready", 32'(rdy), 32'(m_ready()));
        chk("model_tick", 32'(tk), 32'(m_tick(TD)));
        chk("model_loss", 32'(loss), 32'(mloss));
        chk("model1_rst_stage", 32'(rs1), 32'(m_rs()));
        chk("model1_ready", 32'(rdy1), 32'(m_ready()));
        chk("model1_tick", 32'(tk1), 32'(m_tick(1)));
        chk("model1_loss", 32'(loss1), 32'(mloss));
    endtask

    task automatic step(input int n);
        repeat (n) begin
            @(posedge CLKIN);
            #1;
            cmp_model();
        end
    endtask

    task automatic do_reset();
        RESET = 1'b1; lock = 1'b0; sw_rst = 1'b0;
        step(2);
        RESET = 1'b0;
        step(1);
    endtask

    task automatic bringup(input string tag);
        int cur = 0;
        lock = 1'b1;
        for (int k = 0; k < 13; k++) begin
            step(bring[k].e - cur);
            cur = bring[k].e;
            chk({tag, "_rst_stage"}, 32'(rs), 32'(bring[k].rs));
            chk({tag, "_ready"}, 32'(rdy), 32'(bring[k].rdy));
            chk({tag, "_tick"}, 32'(tk), 32'(bring[k].tk));
        end
    endtask

    task automatic wait_ready(input int budget);
        int n = 0;
        while (!rdy && n < budget) begin
            step(1);
            n++;
        end
        chk("ready_timeout", 32'(rdy), 32'(1));
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        bring[0]  = '{6, 2'b11, 1'b0, 1'b0};
        bring[1]  = '{7, 2'b10, 1'b0, 1'b0};
        bring[2]  = '{8, 2'b10, 1'b0, 1'b0};
        bring[3]  = '{9, 2'b00, 1'b0, 1'b0};
        bring[4]  = '{10, 2'b00, 1'b0, 1'b0};
        bring[5]  = '{11, 2'b00, 1'b1, 1'b0};
        bring[6]  = '{12, 2'b00, 1'b1, 1'b0};
        bring[7]  = '{13, 2'b00, 1'b1, 1'b0};
        bring[8]  = '{14, 2'b00, 1'b1, 1'b1};
        bring[9]  = '{15, 2'b00, 1'b1, 1'b0};
        bring[10] = '{16, 2'b00, 1'b1, 1'b0};
        bring[11] = '{17, 2'b00, 1'b1, 1'b1};
        bring[12] = '{20, 2'b00, 1'b1, 1'b1};

        #12;
        chk("reset_rst_stage", 32'(rs), 32'(2'b11));
        chk("reset_ready", 32'(rdy), 32'(0));
        chk("reset_tick", 32'(tk), 32'(0));
        chk("reset_loss", 32'(loss), 32'(0));
        do_reset();
        bringup("bringup");

        lock = 1'b0;
        step(2);
        chk("loss_latency_ready", 32'(rdy), 32'(1));
        step(1);
        chk("loss_rst_stage", 32'(rs), 32'(2'b11));
        chk("loss_ready", 32'(rdy), 32'(0));
        chk("loss_tick", 32'(tk), 32'(0));
        chk("loss_cnt", 32'(loss), 32'(1));
        bringup("relock");

        sw_rst = 1'b1;
        step(1);
        chk("sw_rst_stage", 32'(rs), 32'(2'b11));
        chk("sw_ready", 32'(rdy), 32'(0));
        chk("sw_loss", 32'(loss), 32'(1));
        step(2);
        sw_rst = 1'b0;
        wait_ready(40);
        for (int k = 0; k < 5; k++) begin
            step(1);
            chk("tick_div1", 32'(tk1), 32'(1));
        end
        chk("sw_loss_after", 32'(loss1), 32'(1));

        do_reset();
        lock = 1'b1;
        step(3);
        lock = 1'b0;
        step(1);
        lock = 1'b1;
        step(3);
        chk("glitch_e7", 32'(rs), 32'(2'b11));
        step(3);
        chk("glitch_e10", 32'(rs), 32'(2'b11));
        step(1);
        chk("glitch_e11", 32'(rs), 32'(2'b10));
        chk("glitch_loss", 32'(loss), 32'(0));

        do_reset();
        for (int k = 0; k < 260; k++) begin
            lock = 1'b1;
            wait_ready(60);
            lock = 1'b0;
            step(3);
        end
        chk("saturate", 32'(loss), 32'(255));

        lock = 1'b1;
        step(8);
        chk("mid_release", 32'(rs), 32'(2'b10));
        #2 RESET = 1'b1;
        #1;
        chk("async_rst_stage", 32'(rs), 32'(2'b11));
        chk("async_ready", 32'(rdy), 32'(0));
        chk("async_loss", 32'(loss), 32'(0));
        do_reset();
        bringup("post_reset");

        for (int k = 0; k < 4000; k++) begin
            if ($urandom_range(0, 39) == 0) lock = ~lock;
            sw_rst = $urandom_range(0, 59) == 0;
            RESET = $urandom_range(0, 799) == 0;
            step(1);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
